// File: rtl/tmds_pkg.sv
// tmds_pkg: control-token codes, lock/watchdog limits and FSM states for the TMDS receive channel
package tmds_pkg;
  localparam logic [9:0] TOK_C00 = 10'b1101010100;
  localparam logic [9:0] TOK_C01 = 10'b0010101011;
  localparam logic [9:0] TOK_C10 = 10'b0101010100;
  localparam logic [9:0] TOK_C11 = 10'b1010101011;
  localparam int LOCK_TOKENS    = 8;
  localparam int WATCHDOG_WORDS = 4096;
  typedef enum logic {HUNT, LOCKED} state_t;
endpackage

// File: rtl/tmds_symbol_decode.sv
// tmds_symbol_decode: combinational 10b->8b TMDS symbol decode with control-token detection
module tmds_symbol_decode (
  input  logic [9:0] q,
  output logic [7:0] d,
  output logic       is_token,
  output logic       c0,
  output logic       c1
);
  import tmds_pkg::*;
  logic [7:0] w_q;
  assign w_q      = q[9] ? ~q[7:0] : q[7:0];
  assign d        = {q[8] ? w_q[7:1] ^ w_q[6:0] : ~(w_q[7:1] ^ w_q[6:0]), w_q[0]};
  assign is_token = (q == TOK_C00) || (q == TOK_C01) || (q == TOK_C10) || (q == TOK_C11);
  assign c0       = (q == TOK_C01) || (q == TOK_C11);
  assign c1       = (q == TOK_C10) || (q == TOK_C11);
endmodule

// File: rtl/tmds_rx_channel.sv
// tmds_rx_channel: TMDS serial deserialiser with token-based symbol alignment and decode; TMDS_RX_LOSSCNT_EN adds a lock-loss counter
module tmds_rx_channel (
  input  logic        tmds_clk,
  input  logic        reset,
  input  logic        in_tmds,
  output logic        out_pixel,
  output logic [7:0]  out_data,
  output logic        out_de,
  output logic        out_c0,
  output logic        out_c1,
`ifdef TMDS_RX_LOSSCNT_EN
  output logic [15:0] out_loss_count,
`endif
  output logic        out_locked
);
  import tmds_pkg::*;
  logic [9:0]  r_sr;
  logic [3:0]  r_bit_cnt;
  logic [2:0]  r_tok_cnt;
  logic [11:0] r_wd;
  state_t      r_state;
  logic [9:0]  w_word;
  logic [7:0]  w_d;
  logic        w_tok, w_c0, w_c1, w_bound, w_slip;
  assign w_word  = {in_tmds, r_sr[9:1]};
  assign w_bound = r_bit_cnt == 4'd9;
  assign w_slip  = w_bound && r_state == HUNT && !w_tok;
  tmds_symbol_decode u_dec (
    .q        (w_word),
    .d        (w_d),
    .is_token (w_tok),
    .c0       (w_c0),
    .c1       (w_c1)
  );
  // Shift bits in LSB-first; a slip parks the counter at 15 so it wraps to 0 one cycle late
  always_ff @(posedge tmds_clk or posedge reset)
    if (reset) begin
      r_sr      <= '0;
      r_bit_cnt <= '0;
    end else begin
      r_sr      <= w_word;
      r_bit_cnt <= w_slip ? 4'd15 : w_bound ? 4'd0 : r_bit_cnt + 4'd1;
    end
  // Alignment FSM with registered symbol outputs, updated only on word boundaries
  always_ff @(posedge tmds_clk or posedge reset)
    if (reset) begin
      r_state    <= HUNT;
      r_tok_cnt  <= '0;
      r_wd       <= '0;
      out_pixel  <= 1'b0;
      out_data   <= '0;
      out_de     <= 1'b0;
      out_c0     <= 1'b0;
      out_c1     <= 1'b0;
      out_locked <= 1'b0;
`ifdef TMDS_RX_LOSSCNT_EN
      out_loss_count <= '0;
`endif
    end else begin
      out_pixel <= 1'b0;
      if (w_bound && r_state == HUNT) begin
        r_tok_cnt <= w_tok ? r_tok_cnt + 3'd1 : 3'd0;
        if (w_tok && r_tok_cnt == 3'(LOCK_TOKENS - 1)) begin
          r_state    <= LOCKED;
          out_locked <= 1'b1;
          r_tok_cnt  <= '0;
          r_wd       <= '0;
          out_pixel  <= 1'b1;
          out_de     <= 1'b0;
          out_c0     <= w_c0;
          out_c1     <= w_c1;
        end
      end else if (w_bound) begin
        out_pixel <= 1'b1;
        out_de    <= !w_tok;
        if (w_tok) begin
          out_c0 <= w_c0;
          out_c1 <= w_c1;
          r_wd   <= '0;
        end else begin
          out_data <= w_d;
          r_wd     <= r_wd + 12'd1;
          if (r_wd == 12'(WATCHDOG_WORDS - 1)) begin
            r_state    <= HUNT;
            out_locked <= 1'b0;
            r_wd       <= '0;
`ifdef TMDS_RX_LOSSCNT_EN
            if (out_loss_count != 16'hFFFF) out_loss_count <= out_loss_count + 16'd1;
`endif
          end
        end
      end
    end
endmodule

// File: tb/tb_tmds_rx_channel.sv
// tb_tmds_rx_channel: table vectors plus scoreboard of expected strobes for tmds_rx_channel
module tb_tmds_rx_channel;
  logic tmds_clk = 1'b0, reset = 1'b1, in_tmds = 1'b0;
  logic out_pixel, out_de, out_c0, out_c1, out_locked;
  logic [7:0] out_data;
`ifdef TMDS_RX_LOSSCNT_EN
  logic [15:0] out_loss_count;
`endif
  typedef struct {logic [7:0] data; logic de, c0, c1, locked;} exp_t;
  typedef struct {logic [9:0] q; logic [7:0] data; logic de, c0, c1;} vec_t;
  localparam logic [9:0] T00 = 10'b1101010100;
  localparam logic [9:0] T01 = 10'b0010101011;
  localparam logic [9:0] T10 = 10'b0101010100;
  localparam logic [9:0] T11 = 10'b1010101011;
  exp_t sb_q[$];
  bit sb_on = 1'b0;
  int n_cmp = 0, n_bad = 0;
  logic [7:0] m_data = '0;
  logic m_c0 = 1'b0, m_c1 = 1'b0;

  tmds_rx_channel dut (
    .tmds_clk       (tmds_clk),
    .reset          (reset),
    .in_tmds        (in_tmds),
    .out_pixel      (out_pixel),
    .out_data       (out_data),
    .out_de         (out_de),
    .out_c0         (out_c0),
    .out_c1         (out_c1),
`ifdef TMDS_RX_LOSSCNT_EN
    .out_loss_count (out_loss_count),
`endif
    .out_locked     (out_locked)
  );

  always #5 tmds_clk = ~tmds_clk;

  initial begin
    #1_200_000;
    $display("FAIL timeout: time limit reached before summary");
    $fatal(1, "time limit");
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // every strobe is matched against the oldest pending expectation
  always @(negedge tmds_clk)
    if (out_pixel && sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      n_cmp++;
      if ({out_data, out_de, out_c0, out_c1, out_locked} !== {e.data, e.de, e.c0, e.c1, e.locked}) begin
        n_bad++;
        $display("FAIL pixel: got data=%h de=%b c0=%b c1=%b lk=%b want data=%h de=%b c0=%b c1=%b lk=%b",
                 out_data, out_de, out_c0, out_c1, out_locked, e.data, e.de, e.c0, e.c1, e.locked);
      end
    end else if (out_pixel && sb_on) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_pixel: got strobe data=%h lk=%b want none", out_data, out_locked);
    end

  function automatic logic [9:0] encode(input logic [7:0] d, input logic inv);
    logic [8:0] qm;
    logic xn;
    xn = $countones(d) > 4 || ($countones(d) == 4 && !d[0]);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = !xn;
    return {inv, qm[8], inv ? ~qm[7:0] : qm[7:0]};
  endfunction

  function automatic logic [9:0] tok(input logic [1:0] c);
    return c == 2'b00 ? T00 : c == 2'b01 ? T01 : c == 2'b10 ? T10 : T11;
  endfunction

  task automatic send_bit(input logic b);
    in_tmds = b;
    @(posedge tmds_clk);
    #1;
  endtask

  task automatic send_word(input logic [9:0] q);
    for (int i = 0; i < 10; i++) send_bit(q[i]);
  endtask

  task automatic push(input logic [7:0] d, input logic de, input logic c0, input logic c1, input logic lk);
    exp_t e;
    e.data = d; e.de = de; e.c0 = c0; e.c1 = c1; e.locked = lk;
    sb_q.push_back(e);
  endtask

  task automatic send_data(input logic [7:0] d, input logic inv, input logic lk);
    m_data = d;
    push(d, 1'b1, m_c0, m_c1, lk);
    send_word(encode(d, inv));
  endtask

  task automatic send_tok(input logic [1:0] c, input logic lk);
    m_c0 = c[0];
    m_c1 = c[1];
    push(m_data, 1'b0, m_c0, m_c1, lk);
    send_word(tok(c));
  endtask

  task automatic hunt_lock(input string tag);
    sb_on = 1'b0;
    repeat (20) send_word(T00);
    @(negedge tmds_clk);
    chk({tag, "_pixel"}, 16'(out_pixel), 16'd1);
    chk({tag, "_locked"}, 16'(out_locked), 16'd1);
    chk({tag, "_de"}, 16'(out_de), 16'd0);
    chk({tag, "_c0"}, 16'(out_c0), 16'd0);
    chk({tag, "_c1"}, 16'(out_c1), 16'd0);
    m_c0 = 1'b0;
    m_c1 = 1'b0;
    #1 sb_on = 1'b1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pixel"}, 16'(out_pixel), 16'd0);
    chk({tag, "_data"}, 16'(out_data), 16'd0);
    chk({tag, "_de"}, 16'(out_de), 16'd0);
    chk({tag, "_c0"}, 16'(out_c0), 16'd0);
    chk({tag, "_c1"}, 16'(out_c1), 16'd0);
    chk({tag, "_locked"}, 16'(out_locked), 16'd0);
`ifdef TMDS_RX_LOSSCNT_EN
    chk({tag, "_loss"}, out_loss_count, 16'd0);
`endif
  endtask

  initial begin
    vec_t tbl[12];
    tbl[0]  = '{10'b0100000000, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{10'b0100001111, 8'h11, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{T01,            8'h11, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{10'b0111111111, 8'h01, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{T10,            8'h01, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{10'b1011111111, 8'hFE, 1'b1, 1'b0, 1'b1};
    tbl[6]  = '{T11,            8'hFE, 1'b0, 1'b1, 1'b1};
    tbl[7]  = '{10'b0100000001, 8'h03, 1'b1, 1'b1, 1'b1};
    tbl[8]  = '{10'b1100000000, 8'h01, 1'b1, 1'b1, 1'b1};
    tbl[9]  = '{10'b0010101010, 8'h00, 1'b1, 1'b1, 1'b1};
    tbl[10] = '{T00,            8'h00, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{10'b0001010101, 8'h01, 1'b1, 1'b0, 1'b0};
    repeat (3) @(posedge tmds_clk);
    #1;
    chk_zero("reset");
    @(negedge tmds_clk);
    reset = 1'b0;
    repeat (3) send_bit(1'b0);
    hunt_lock("lock_misalign");
    for (int i = 0; i < 12; i++) begin
      push(tbl[i].data, tbl[i].de, tbl[i].c0, tbl[i].c1, 1'b1);
      m_data = tbl[i].data;
      m_c0 = tbl[i].c0;
      m_c1 = tbl[i].c1;
      send_word(tbl[i].q);
    end
    send_tok(2'b00, 1'b1);
    for (int k = 0; k < 4095; k++) send_data(k[7:0], k[8], 1'b1);
    send_tok(2'b00, 1'b1);
    for (int k = 0; k < 4096; k++) send_data(k[7:0], k[8], k != 4095);
    repeat (2) send_word(encode(8'h5A, 1'b0));
    @(negedge tmds_clk);
    #1;
    chk("wd_drain", 16'(sb_q.size()), 16'd0);
    chk("wd_locked", 16'(out_locked), 16'd0);
`ifdef TMDS_RX_LOSSCNT_EN
    chk("wd_loss", out_loss_count, 16'd1);
`endif
    hunt_lock("relock");
`ifdef TMDS_RX_LOSSCNT_EN
    chk("relock_loss", out_loss_count, 16'd1);
`endif
    send_tok(2'b11, 1'b1);
    for (int i = 0; i < 4; i++) send_bit(encode(8'h3C, 1'b0)[i]);
    sb_on = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk_zero("midword_reset");
    chk("midword_drain", 16'(sb_q.size()), 16'd0);
    @(negedge tmds_clk);
    reset = 1'b0;
    m_data = '0;
    m_c0 = 1'b0;
    m_c1 = 1'b0;
    sb_on = 1'b1;
    repeat (7) send_word(T00);
    chk("after7_locked", 16'(out_locked), 16'd0);
    send_tok(2'b00, 1'b1);
    chk("after8_locked", 16'(out_locked), 16'd1);
    send_data(8'hA5, 1'b1, 1'b1);
    @(negedge tmds_clk);
    #1;
    chk("final_drain", 16'(sb_q.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
